// File: rtl/rgb_pwm_pkg.sv
// Shared types and constants for the RGB PWM sequencer.
package rgb_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  localparam int DEF_CHANNELS    = 3;
  localparam int DEF_PWM_BITS    = 8;
  localparam int DEF_PRESCALE    = 48000;
  localparam int DEF_BLINK_TICKS = 250;

  // Width of the channel-select field on the config port.
  localparam int CFG_CH_BITS = 3;

  // Bits needed to hold values 0..n-1; never less than one so counters stay legal.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM channel: mode/level registers, blink timer, breathing envelope,
// period-boundary duty shadow and the registered output compare.
module rgb_pwm_channel
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_BITS    = DEF_PWM_BITS,
  parameter int BLINK_TICKS = DEF_BLINK_TICKS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                tick,
  input  logic                load,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                wr,
  input  logic [1:0]          wr_mode,
  input  logic [PWM_BITS-1:0] wr_level,
  output logic                pwm
);

  localparam int BW = clog2(BLINK_TICKS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  mode_t               mode_q, mode_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] env_q, env_d;
  logic                down_q, down_d;
  logic                phase_q, phase_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic [PWM_BITS-1:0] duty_target;
  logic [PWM_BITS-1:0] duty_active_q, duty_active_d;
  logic                pwm_q, pwm_d;

  // Duty the current mode asks for; only sampled into the shadow at period end.
  always_comb begin
    duty_target = '0;
    case (mode_q)
      MODE_OFF:     duty_target = '0;
      MODE_SOLID:   duty_target = level_q;
      MODE_BLINK:   duty_target = phase_q ? level_q : '0;
      MODE_BREATHE: duty_target = env_q;
      default:      duty_target = '0;
    endcase
  end

  // Next state: a config write takes priority over the animation tick.
  always_comb begin
    mode_d        = mode_q;
    level_d       = level_q;
    env_d         = env_q;
    down_d        = down_q;
    phase_d       = phase_q;
    bcnt_d        = bcnt_q;
    duty_active_d = load ? duty_target : duty_active_q;
    pwm_d         = en & (pwm_cnt < duty_active_q);
    if (wr) begin
      mode_d  = mode_t'(wr_mode);
      level_d = wr_level;
      if (mode_t'(wr_mode) != mode_q) begin
        env_d   = '0;
        down_d  = 1'b0;
        phase_d = 1'b0;
        bcnt_d  = '0;
      end
    end else if (tick) begin
      case (mode_q)
        MODE_BLINK: begin
          if (bcnt_q == BLINK_LAST) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        MODE_BREATHE: begin
          if (!down_q) begin
            if (env_q < level_q) env_d = env_q + 1'b1;
            else                 down_d = 1'b1;
          end else begin
            if (env_q != '0) env_d = env_q - 1'b1;
            else             down_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q        <= MODE_OFF;
      level_q       <= '0;
      env_q         <= '0;
      down_q        <= 1'b0;
      phase_q       <= 1'b0;
      bcnt_q        <= '0;
      duty_active_q <= '0;
      pwm_q         <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      level_q       <= level_d;
      env_q         <= env_d;
      down_q        <= down_d;
      phase_q       <= phase_d;
      bcnt_q        <= bcnt_d;
      duty_active_q <= duty_active_d;
      pwm_q         <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// Multi-channel LED PWM engine: shared prescaler and PWM counter,
// config write decode, and one rgb_pwm_channel per output.
module rgb_pwm_sequencer
  import rgb_pwm_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int PWM_BITS    = DEF_PWM_BITS,
  parameter int PRESCALE    = DEF_PRESCALE,
  parameter int BLINK_TICKS = DEF_BLINK_TICKS
) (
  input  logic                   int_osc,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   cfg_we,
  input  logic [CFG_CH_BITS-1:0] cfg_ch,
  input  logic [1:0]             cfg_mode,
  input  logic [PWM_BITS-1:0]    cfg_level,
  output logic [CHANNELS-1:0]    pwm,
  output logic                   period_start
);

  localparam int PSW = clog2(PRESCALE);
  localparam logic [PSW-1:0] PRESC_LAST = PSW'(PRESCALE - 1);
  localparam logic [CFG_CH_BITS:0] CH_LIMIT = (CFG_CH_BITS + 1)'(CHANNELS);

  logic [PSW-1:0]      presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                period_start_q, period_start_d;
  logic                tick;
  logic                load;
  logic                cfg_valid;

  // Shared timing: animation tick, period-end shadow load, free-running counters.
  always_comb begin
    tick           = (presc_q == PRESC_LAST);
    load           = (pwm_cnt_q == '1);
    cfg_valid      = cfg_we && ({1'b0, cfg_ch} < CH_LIMIT);
    presc_d        = tick ? '0 : presc_q + 1'b1;
    pwm_cnt_d      = pwm_cnt_q + 1'b1;
    period_start_d = (pwm_cnt_q == '0);
  end

  // Counter and period marker registers.
  always_ff @(posedge int_osc or posedge rst) begin
    if (rst) begin
      presc_q        <= '0;
      pwm_cnt_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      pwm_cnt_q      <= pwm_cnt_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic wr;
    assign wr = cfg_valid && (cfg_ch == CFG_CH_BITS'(i));

    rgb_pwm_channel #(
      .PWM_BITS   (PWM_BITS),
      .BLINK_TICKS(BLINK_TICKS)
    ) u_ch (
      .clk     (int_osc),
      .rst     (rst),
      .en      (en),
      .tick    (tick),
      .load    (load),
      .pwm_cnt (pwm_cnt_q),
      .wr      (wr),
      .wr_mode (cfg_mode),
      .wr_level(cfg_level),
      .pwm     (pwm[i])
    );
  end

endmodule
